rx_cmd_ctrl: RTL

Command controller that sits behind the UART receiver. It consumes validated bytes from the receiver (parallel data plus data-valid pulse) and decodes them into register-file write/read and ALU operation sequences. It returns read data and ALU results to a UART transmitter through a valid/busy handshake. It also drives the ALU clock-gate enable.

---
 rtl/rx_cmd_pkg.sv | 32 +++
 rtl/rx_cmd_tx_seq.sv | 55 +++++
 rtl/rx_cmd_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/rx_cmd_pkg.sv
// Shared constants and state encoding for the UART command controller.
package rx_cmd_pkg;

    localparam logic [7:0] CMD_WR     = 8'hAA;
    localparam logic [7:0] CMD_RD     = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP = 8'hCC;
    localparam logic [7:0] CMD_ALU    = 8'hDD;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        OP_A,
        OP_B,
        ALU_FUN,
        ALU_WAIT,
        TX_LO,
        TX_HI
    } state_t;

    // States in which a command is half-received and waiting on the UART.
    function automatic logic is_partial(input state_t st);
        return (st == WR_ADDR) || (st == WR_DATA) || (st == RD_ADDR) ||
               (st == OP_A)    || (st == OP_B)    || (st == ALU_FUN);
    endfunction

endpackage

// File: rtl/rx_cmd_tx_seq.sv
// Presents a one- or two-byte response (low byte first) to the UART transmitter
// using a valid/busy handshake; a byte is taken when valid is high and busy is low.
module rx_cmd_tx_seq #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2*DATA_W-1:0]   payload,
    input  logic [1:0]            byte_cnt,
    input  logic                  tx_busy,
    output logic [DATA_W-1:0]     tx_p_data,
    output logic                  tx_d_valid,
    output logic                  byte_acc,
    output logic                  done
);

    logic              valid_reg;
    logic [DATA_W-1:0] data_reg;
    logic [DATA_W-1:0] hi_reg;
    logic              hi_pend_reg;
    logic              gap_reg;

    assign tx_p_data  = data_reg;
    assign tx_d_valid = valid_reg;
    assign byte_acc   = valid_reg & ~tx_busy;
    assign done       = byte_acc & ~hi_pend_reg;

    // After an accepted low byte, one idle cycle passes before the high byte appears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg   <= 1'b0;
            data_reg    <= '0;
            hi_reg      <= '0;
            hi_pend_reg <= 1'b0;
            gap_reg     <= 1'b0;
        end else begin
            gap_reg <= 1'b0;
            if (start) begin
                valid_reg   <= 1'b1;
                data_reg    <= payload[DATA_W-1:0];
                hi_reg      <= payload[2*DATA_W-1:DATA_W];
                hi_pend_reg <= (byte_cnt == 2'd2);
            end else if (byte_acc) begin
                valid_reg <= 1'b0;
                gap_reg   <= hi_pend_reg;
            end else if (gap_reg) begin
                valid_reg   <= 1'b1;
                data_reg    <= hi_reg;
                hi_pend_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rx_cmd_ctrl.sv
// Decodes UART bytes into register-file and ALU operations and returns results to the
// transmitter. Define CMD_TIMEOUT_EN to abandon partial commands after TIMEOUT_CYC idle cycles.
module rx_cmd_ctrl
    import rx_cmd_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int FUN_W       = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     rx_p_data,
    input  logic                  rx_d_valid,
    output logic                  rf_wr_en,
    output logic                  rf_rd_en,
    output logic [ADDR_W-1:0]     rf_addr,
    output logic [DATA_W-1:0]     rf_wr_data,
    input  logic [DATA_W-1:0]     rf_rd_data,
    input  logic                  rf_rd_data_valid,
    output logic                  alu_en,
    output logic [FUN_W-1:0]      alu_fun,
    input  logic [2*DATA_W-1:0]   alu_out,
    input  logic                  alu_out_valid,
    output logic                  clk_gate_en,
    output logic [DATA_W-1:0]     tx_p_data,
    output logic                  tx_d_valid,
    input  logic                  tx_busy
);

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   rf_addr_reg, rf_addr_next;
    logic [DATA_W-1:0]   rf_wr_data_reg, rf_wr_data_next;
    logic [FUN_W-1:0]    alu_fun_reg, alu_fun_next;
    logic                rf_wr_en_reg, rf_wr_en_next;
    logic                rf_rd_en_reg, rf_rd_en_next;
    logic                alu_en_reg, alu_en_next;
    logic                gate_en;
    logic                tmo_hit;

    logic                tx_start;
    logic [2*DATA_W-1:0] tx_payload;
    logic [1:0]          tx_cnt;
    logic                tx_acc;
    logic                tx_done;

`ifdef CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC);

    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             timed;

    assign timed   = is_partial(state_reg);
    assign tmo_hit = timed && !rx_d_valid && (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_reg <= '0;
        end else if (rx_d_valid || !timed) begin
            tmo_cnt_reg <= '0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_next      = state_reg;
        rf_addr_next    = rf_addr_reg;
        rf_wr_data_next = rf_wr_data_reg;
        alu_fun_next    = alu_fun_reg;
        rf_wr_en_next   = 1'b0;
        rf_rd_en_next   = 1'b0;
        alu_en_next     = 1'b0;
        gate_en         = 1'b0;
        tx_start        = 1'b0;
        tx_payload      = '0;
        tx_cnt          = 2'd1;

        unique case (state_reg)
            IDLE: begin
                if (rx_d_valid) begin
                    case (rx_p_data)
                        CMD_WR:     state_next = WR_ADDR;
                        CMD_RD:     state_next = RD_ADDR;
                        CMD_ALU_OP: state_next = OP_A;
                        CMD_ALU:    state_next = ALU_FUN;
                        default:    state_next = IDLE;
                    endcase
                end
            end
            WR_ADDR: begin
                if (rx_d_valid) begin
                    rf_addr_next = rx_p_data[ADDR_W-1:0];
                    state_next   = WR_DATA;
                end
            end
            WR_DATA: begin
                if (rx_d_valid) begin
                    rf_wr_data_next = rx_p_data;
                    rf_wr_en_next   = 1'b1;
                    state_next      = IDLE;
                end
            end
            RD_ADDR: begin
                if (rx_d_valid) begin
                    rf_addr_next  = rx_p_data[ADDR_W-1:0];
                    rf_rd_en_next = 1'b1;
                    state_next    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rf_rd_data_valid) begin
                    tx_start   = 1'b1;
                    tx_payload = {{DATA_W{1'b0}}, rf_rd_data};
                    tx_cnt     = 2'd1;
                    state_next = TX_LO;
                end
            end
            OP_A: begin
                if (rx_d_valid) begin
                    rf_addr_next    = ADDR_W'(OPA_ADDR);
                    rf_wr_data_next = rx_p_data;
                    rf_wr_en_next   = 1'b1;
                    state_next      = OP_B;
                end
            end
            OP_B: begin
                if (rx_d_valid) begin
                    rf_addr_next    = ADDR_W'(OPB_ADDR);
                    rf_wr_data_next = rx_p_data;
                    rf_wr_en_next   = 1'b1;
                    state_next      = ALU_FUN;
                end
            end
            ALU_FUN: begin
                // The gate opens combinationally so the ALU clock runs before alu_en arrives.
                if (rx_d_valid) begin
                    alu_fun_next = rx_p_data[FUN_W-1:0];
                    alu_en_next  = 1'b1;
                    gate_en      = 1'b1;
                    state_next   = ALU_WAIT;
                end
            end
            ALU_WAIT: begin
                gate_en = 1'b1;
                if (alu_out_valid) begin
                    tx_start   = 1'b1;
                    tx_payload = alu_out;
                    tx_cnt     = 2'd2;
                    state_next = TX_LO;
                end
            end
            TX_LO: begin
                if (tx_acc) begin
                    state_next = tx_done ? IDLE : TX_HI;
                end
            end
            TX_HI: begin
                if (tx_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (tmo_hit) begin
            state_next = IDLE;
            gate_en    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            rf_addr_reg    <= '0;
            rf_wr_data_reg <= '0;
            alu_fun_reg    <= '0;
            rf_wr_en_reg   <= 1'b0;
            rf_rd_en_reg   <= 1'b0;
            alu_en_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rf_addr_reg    <= rf_addr_next;
            rf_wr_data_reg <= rf_wr_data_next;
            alu_fun_reg    <= alu_fun_next;
            rf_wr_en_reg   <= rf_wr_en_next;
            rf_rd_en_reg   <= rf_rd_en_next;
            alu_en_reg     <= alu_en_next;
        end
    end

    assign rf_addr     = rf_addr_reg;
    assign rf_wr_data  = rf_wr_data_reg;
    assign alu_fun     = alu_fun_reg;
    assign rf_wr_en    = rf_wr_en_reg;
    assign rf_rd_en    = rf_rd_en_reg;
    assign alu_en      = alu_en_reg;
    assign clk_gate_en = gate_en;

    rx_cmd_tx_seq #(
        .DATA_W (DATA_W)
    ) u_tx_seq (
        .clk        (clk),
        .rst        (rst),
        .start      (tx_start),
        .payload    (tx_payload),
        .byte_cnt   (tx_cnt),
        .tx_busy    (tx_busy),
        .tx_p_data  (tx_p_data),
        .tx_d_valid (tx_d_valid),
        .byte_acc   (tx_acc),
        .done       (tx_done)
    );

endmodule
